// File: rtl/w0rm_gpio_pkg.sv
// Shared types and defaults for the w0rm GPIO debounce block.
package w0rm_gpio_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000;

endpackage

// File: rtl/w0rm_debounce_bit.sv
// One GPIO bit: two-flop synchronizer, hold counter and STABLE/PENDING FSM.
module w0rm_debounce_bit
  import w0rm_gpio_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic accept
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync_a_q, sync_b_q;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          accept_q, accept_d;

  // The counter tops out at CNT_MAX and is cleared on acceptance, so it never wraps.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    accept_d = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync_b_q != level_q) begin
          state_d = ST_PENDING;
          cnt_d   = CW'(1);
        end
      end
      ST_PENDING: begin
        if (sync_b_q == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d  = ST_STABLE;
          cnt_d    = '0;
          level_d  = ~level_q;
          accept_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_a_q <= 1'b0;
      sync_b_q <= 1'b0;
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      accept_q <= 1'b0;
    end else begin
      sync_a_q <= pin;
      sync_b_q <= sync_a_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      accept_q <= accept_d;
    end
  end

  assign level  = level_q;
  // High in the first cycle the new level is visible.
  assign accept = accept_q;

endmodule

// File: rtl/w0rm_gpio_debounce.sv
// GPIO debounce with optional sticky edge capture and interrupt.
// Edge capture is built only when W0RM_GPIO_DEBOUNCE_EDGE_IRQ_EN is defined.
module w0rm_gpio_debounce
  import w0rm_gpio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] edge_bits,
  output logic             irq_valid,
  input  logic             irq_ack
);

  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    w0rm_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .pin    (pin_in[i]),
      .level  (level[i]),
      .accept (accept[i])
    );
  end

  assign gpio_out = level;

`ifdef W0RM_GPIO_DEBOUNCE_EDGE_IRQ_EN
  logic [WIDTH-1:0] edge_q, edge_d, captured;
  logic             irq_q;

  // Clear first, then OR in new captures so a same-cycle edge survives the ack.
  always_comb begin
    captured = accept & ((level & rise_en) | (~level & fall_en));
    edge_d   = edge_q;
    if (irq_ack && irq_q) begin
      edge_d = '0;
    end
    edge_d = edge_d | captured;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      edge_q <= edge_d;
      irq_q  <= |edge_d;
    end
  end

  assign edge_bits = edge_q;
  assign irq_valid = irq_q;
`else
  logic unused_edge_inputs;
  assign unused_edge_inputs = ^{rise_en, fall_en, irq_ack, accept};

  assign edge_bits = '0;
  assign irq_valid = 1'b0;
`endif

endmodule

// File: tb/tb_w0rm_gpio_debounce.sv
// Bench for w0rm_gpio_debounce (WIDTH=8, DEBOUNCE_CYCLES=4): directed steps plus random pins
// checked against a window-based reference model of the debounce and edge-capture rules.
module tb_w0rm_gpio_debounce;

  localparam int unsigned W    = 8;
  localparam int unsigned D    = 4;
  localparam int          MAXE = 4096;
`ifdef W0RM_GPIO_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pin_in, rise_en, fall_en;
  logic         irq_ack;
  logic [W-1:0] gpio_out, edge_bits;
  logic         irq_valid;

  always #5 clk = ~clk;

  w0rm_gpio_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pin_in   (pin_in),
    .rise_en  (rise_en),
    .fall_en  (fall_en),
    .gpio_out (gpio_out),
    .edge_bits(edge_bits),
    .irq_valid(irq_valid),
    .irq_ack  (irq_ack)
  );

  int checks   = 0;
  int failures = 0;

  // Raw history of every rising edge: pin value and whether reset was asserted.
  logic [W-1:0] samp_h[MAXE];
  bit           rst_h [MAXE];
  int           ecount = 0;

  logic [W-1:0] m_level = '0;
  logic [W-1:0] m_edges = '0;
  logic [W-1:0] m_acc   = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // A bit flips at edge n when the pin value seen through the two-stage delay differed from
  // the current level at each of the last D+1 edges, none of them in or just after reset.
  task automatic model_step();
    int           n;
    logic [W-1:0] acc;
    bit           ok;
    n   = ecount;
    acc = '0;
    samp_h[n] = pin_in;
    rst_h[n]  = !reset_n;
    if (!reset_n) begin
      m_level = '0;
      m_edges = '0;
      m_acc   = '0;
    end else begin
      if (EDGE_EN) begin
        if (irq_ack && m_edges != '0) m_edges = '0;
        m_edges = m_edges | (m_acc & ((m_level & rise_en) | (~m_level & fall_en)));
      end
      if (n >= int'(D) + 2) begin
        for (int b = 0; b < int'(W); b++) begin
          ok = 1'b1;
          for (int k = n - int'(D); k <= n; k++) begin
            if (rst_h[k] || rst_h[k-1] || rst_h[k-2] || samp_h[k-2][b] == m_level[b]) ok = 1'b0;
          end
          acc[b] = ok;
        end
      end
      m_level = m_level ^ acc;
      m_acc   = acc;
    end
    ecount++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (ecount >= MAXE) begin
      $display("FAIL history_overflow: got %0d edges, expected fewer than %0d", ecount, MAXE);
      $fatal(1);
    end
    model_step();
    @(negedge clk);
    check("model_gpio_out", gpio_out, m_level);
    check("model_edge_bits", edge_bits, m_edges);
    check("model_irq_valid", W'(irq_valid), W'(m_edges != '0));
  endtask

  task automatic wait_gpio(input logic [W-1:0] target, output int n);
    n = 0;
    while (gpio_out !== target && n < 30) begin
      tick();
      n++;
    end
  endtask

  int lat;

  initial begin
    reset_n = 1'b0;
    pin_in  = '0;
    rise_en = '0;
    fall_en = '0;
    irq_ack = 1'b0;
    repeat (3) tick();
    check("reset_gpio_out", gpio_out, 8'h00);
    check("reset_edge_bits", edge_bits, 8'h00);
    check("reset_irq_valid", W'(irq_valid), 8'h00);
    reset_n = 1'b1;
    tick();

    // Clean rising step on bit 0.
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin_in  = 8'h01;
    wait_gpio(8'h01, lat);
    check("rise_latency", W'(lat), 8'd7);
    tick();
    check("rise_edge_bits", edge_bits, EDGE_EN ? 8'h01 : 8'h00);
    check("rise_irq_valid", W'(irq_valid), W'(EDGE_EN));

    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_clears", edge_bits, 8'h00);
    check("ack_irq_low", W'(irq_valid), 8'h00);

    // Three-cycle glitch on bit 2 must be rejected.
    pin_in = 8'h05;
    repeat (3) tick();
    pin_in = 8'h01;
    repeat (10) tick();
    check("glitch_gpio_out", gpio_out, 8'h01);
    check("glitch_edge_bits", edge_bits, 8'h00);

    // Bit 0 falls and is captured, then bit 3 is accepted in the ack cycle.
    pin_in = 8'h00;
    repeat (8) tick();
    check("fall_edge_bits", edge_bits, EDGE_EN ? 8'h01 : 8'h00);
    pin_in = 8'h08;
    wait_gpio(8'h08, lat);
    check("bit3_latency", W'(lat), 8'd7);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check("ack_newedge_bits", edge_bits, EDGE_EN ? 8'h08 : 8'h00);
    check("ack_newedge_irq", W'(irq_valid), W'(EDGE_EN));

    // Edge enables off: levels follow, nothing captured.
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    rise_en = 8'h00;
    fall_en = 8'h00;
    pin_in  = 8'h09;
    repeat (10) tick();
    check("noen_rise_gpio", gpio_out, 8'h09);
    check("noen_rise_edges", edge_bits, 8'h00);
    pin_in = 8'h08;
    repeat (10) tick();
    check("noen_fall_gpio", gpio_out, 8'h08);
    check("noen_fall_edges", edge_bits, 8'h00);
    check("noen_fall_irq", W'(irq_valid), 8'h00);

    // Reset in the middle of a pending change.
    rise_en = 8'hFF;
    fall_en = 8'hFF;
    pin_in  = 8'hFF;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    check("midreset_gpio_0", gpio_out, 8'h00);
    tick();
    check("midreset_gpio_1", gpio_out, 8'h00);
    reset_n = 1'b1;
    wait_gpio(8'hFF, lat);
    check("release_latency", W'(lat), 8'd7);
    tick();
    check("release_edges", edge_bits, EDGE_EN ? 8'hFF : 8'h00);

    // Slow counting pattern: gpio_out must track every value.
    for (int v = 0; v < 16; v++) begin
      pin_in = 8'(v * 17);
      repeat (12) tick();
      check("count_track", gpio_out, 8'(v * 17));
    end

    // Random pins, enables, acks and occasional resets against the model.
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
      else pin_in = pin_in ^ 8'(1 << $urandom_range(0, 7));
      rise_en = 8'($urandom);
      fall_en = 8'($urandom);
      irq_ack = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 40) != 0);
      tick();
      irq_ack = 1'b0;
      reset_n = 1'b1;
      repeat ($urandom_range(0, 11)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
